// File: rtl/seq_player_if.sv
// Handshake and lamp bundle between a sequence-player controller and its driver.
interface seq_player_if;
   logic       start;
   logic [3:0] round;
   logic [7:0] seed;
   logic [3:0] led;
   logic [3:0] idx;
   logic       busy;
   logic       done;

   modport master (
      output start, round, seed,
      input  led, idx, busy, done
   );

   modport slave (
      input  start, round, seed,
      output led, idx, busy, done
   );
endinterface

// File: rtl/seq_player.sv
// Colour-sequence player: replays an LFSR-derived list of one-hot lamp colours,
// each lit for ON_CYCLES and followed by OFF_CYCLES of darkness.
module seq_player #(
   parameter int unsigned ON_CYCLES  = 4,
   parameter int unsigned OFF_CYCLES = 2
) (
   input logic         clk,
   input logic         R,
   seq_player_if.slave bus
);

   localparam int unsigned MaxCycles = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
   // Timer counts 0..phase-1, so it never needs to hold the phase length itself.
   localparam int unsigned TimerW = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
   localparam logic [TimerW-1:0] OnLast  = TimerW'(ON_CYCLES - 1);
   localparam logic [TimerW-1:0] OffLast = TimerW'(OFF_CYCLES - 1);

   typedef enum logic [2:0] {StIdle, StLoad, StOn, StOff, StDone} state_e;

   state_e              state_q, state_d;
   logic [TimerW-1:0]   timer_q, timer_d;
   logic [3:0]          idx_q, idx_d;
   logic [7:0]          lfsr_q, lfsr_d;
   logic [3:0]          round_q, round_d;
   logic [7:0]          seed_q, seed_d;

   function automatic logic [7:0] lfsr_step(input logic [7:0] v);
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

   always_ff @(posedge clk or posedge R) begin
      if (R) begin
         state_q <= StIdle;
         timer_q <= '0;
         idx_q   <= '0;
         lfsr_q  <= 8'h01;
         round_q <= '0;
         seed_q  <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         idx_q   <= idx_d;
         lfsr_q  <= lfsr_d;
         round_q <= round_d;
         seed_q  <= seed_d;
      end
   end

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      idx_d   = idx_q;
      lfsr_d  = lfsr_q;
      round_d = round_q;
      seed_d  = seed_q;
      case (state_q)
         StIdle: begin
            if (bus.start) begin
               round_d = bus.round;
               seed_d  = bus.seed;
               state_d = StLoad;
            end
         end
         StLoad: begin
            // An all-zero LFSR would lock up, so a zero seed plays as seed 1.
            lfsr_d  = (seed_q == 8'h00) ? 8'h01 : seed_q;
            idx_d   = '0;
            timer_d = '0;
            state_d = (round_q == 4'd0) ? StDone : StOn;
         end
         StOn: begin
            if (timer_q == OnLast) begin
               timer_d = '0;
               state_d = StOff;
            end else begin
               timer_d = timer_q + TimerW'(1);
            end
         end
         StOff: begin
            if (timer_q == OffLast) begin
               timer_d = '0;
               lfsr_d  = lfsr_step(lfsr_q);
               if (idx_q + 4'd1 == round_q) begin
                  state_d = StDone;
               end else begin
                  idx_d   = idx_q + 4'd1;
                  state_d = StOn;
               end
            end else begin
               timer_d = timer_q + TimerW'(1);
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   assign bus.led  = (state_q == StOn) ? (4'b0001 << lfsr_q[1:0]) : 4'b0000;
   assign bus.idx  = idx_q;
   assign bus.busy = (state_q == StLoad) || (state_q == StOn) || (state_q == StOff);
   assign bus.done = (state_q == StDone);

endmodule

// File: doc/seq_player.md
SEQ_PLAYER -- requirements
Module: seq_player

Interface
REQ-001 Parameter ON_CYCLES, default 4, clock cycles each colour is lit (>=1).
REQ-002 Parameter OFF_CYCLES, default 2, dark gap after each colour (>=1).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 R  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request playback; sampled only in IDLE.
REQ-006 round  input  4  number of colours to play (0..15); latched on accepted start.
REQ-007 seed  input  8  sequence seed; latched on accepted start.
REQ-008 led  output  4  one-hot colour lamp; 4'b0000 when dark.
REQ-009 idx  output  4  index of the colour currently playing (0-based).
REQ-010 busy  output  1  high while playback is in progress.
REQ-011 done  output  1  one-cycle pulse when playback completes.

Function
REQ-012 FSM states SHALL be IDLE, LOAD, ON, OFF and DONE.
REQ-013 IDLE: start=1 SHALL latch round and seed and go to LOAD; start SHALL be ignored in every other state.
REQ-014 LOAD (1 cycle): lfsr <= seed, with seed 8'h00 replaced by 8'h01; idx <= 0; timer cleared; next ON, or DONE if latched round == 0.
REQ-015 ON: led = one-hot of lfsr[1:0] (0->0001, 1->0010, 2->0100, 3->1000) for exactly ON_CYCLES cycles, then OFF.
REQ-016 OFF: led = 0 for exactly OFF_CYCLES cycles; on the last OFF cycle, lfsr steps, and if idx+1 == latched round go to DONE, else idx increments and go to ON.
REQ-017 LFSR step: lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
REQ-018 DONE (1 cycle): done=1, busy=0, led=0; next IDLE.
REQ-019 busy SHALL be 1 exactly in LOAD, ON and OFF.
REQ-020 Latency: with start sampled at edge t, LOAD is cycle t+1 and colour i is lit in cycles t+2+i*(ON+OFF) .. t+1+i*(ON+OFF)+ON.
REQ-021 done SHALL occur at cycle t+2+N*(ON+OFF) for N>=1, and at t+2 for N=0.
REQ-022 Equal seed and round SHALL always reproduce the same led sequence; round or seed changes during playback SHALL have no effect.
REQ-023 The timer SHALL be wide enough for max(ON_CYCLES, OFF_CYCLES) and SHALL never wrap within a phase.
REQ-024 start held high through DONE SHALL begin a new playback only from IDLE, i.e. the cycle after DONE.

Reset
REQ-025 R=1 SHALL force state IDLE, led=0, idx=0, busy=0, done=0, lfsr=8'h01 and latched round/seed=0 immediately, without waiting for a clock edge.
REQ-026 R asserted mid-playback SHALL abort playback with no done pulse; after release the block SHALL wait in IDLE for a new start.

Verification
REQ-027 seed=8'h01, round=3, defaults, start pulse at t -> led 0010 in t+2..t+5, 0 in t+6..t+7, 0100 in t+8..t+11, 0 in t+12..t+13, 0001 in t+14..t+17, 0 in t+18..t+19; done=1 only at t+20; busy=1 in t+1..t+19.
REQ-028 round=0 -> busy=1 only at t+1, done at t+2, led stays 0.
REQ-029 seed=8'h00, round=2 -> identical output to seed=8'h01, round=2.
REQ-030 Two back-to-back playbacks with seed=8'h5A, round=5 -> identical led/idx traces; round and seed toggled mid-play -> no change.
REQ-031 R pulsed at t+9 during REQ-027 stimulus -> outputs 0 asynchronously, no done; start pulses while busy are ignored.
REQ-032 round=15, seed=8'h01 -> idx runs 0..14, done at t+2+15*6 = t+92.
